mult_datapath: RTL and testbench

MULT_DATAPATH -- requirements
Module: mult_datapath

---
 rtl/mult_datapath.sv | 79 +++++++
 tb/tb_mult_datapath.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath driven by an external control FSM.
// Holds the operand/accumulator registers, the step counter and the result register.
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 clear,
  input  logic                 start_count_flag,
  output logic                 counter_flag,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);

  logic [2*WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [2*WIDTH-1:0] step_sum;

  assign counter_flag = start_count_flag && (cnt_q == CNT_LAST);
  assign product      = res_q;
  assign step_sum     = b_q[0] ? (acc_q + a_q) : acc_q;

  // Command priority is load > clear > shift; res only moves on the final counted step.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    if (load) begin
      a_d   = {{WIDTH{1'b0}}, multiplicand};
      b_d   = multiplier;
      acc_d = '0;
      cnt_d = '0;
    end else if (clear) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
      cnt_d = '0;
    end else if (shift) begin
      acc_d = step_sum;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      if (start_count_flag && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (counter_flag) begin
        res_d = step_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end

endmodule

// File: tb/tb_mult_datapath.sv
// Bench for mult_datapath (WIDTH=8): scripted and random jobs, scoreboard of expected products.
module tb_mult_datapath;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           load;
  logic           shift;
  logic           clear;
  logic           start_count_flag;
  logic           counter_flag;
  logic [2*W-1:0] product;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_val;
  int             errors;
  int             checks;

  mult_datapath #(.WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .multiplicand     (multiplicand),
    .multiplier       (multiplier),
    .load             (load),
    .shift            (shift),
    .clear            (clear),
    .start_count_flag (start_count_flag),
    .counter_flag     (counter_flag),
    .product          (product)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: called at a falling edge; drives one cycle, samples counter_flag before the
  // rising edge and returns at the next falling edge.
  task automatic drive_cycle(input logic l, input logic c, input logic s, input logic f,
                             output logic flag_seen);
    load = l;
    clear = c;
    shift = s;
    start_count_flag = f;
    #1 flag_seen = counter_flag;
    @(negedge clk);
  endtask

  task automatic drive_load(input logic [W-1:0] a, input logic [W-1:0] b);
    logic fl;
    multiplicand = a;
    multiplier = b;
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, fl);
    exp_q.push_back((2*W)'(a) * (2*W)'(b));
  endtask

  task automatic drive_shifts(input logic f, output logic [W-1:0] flags);
    logic fl;
    flags = '0;
    for (int i = 0; i < W; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, f, fl);
      flags[i] = fl;
    end
  endtask

  task automatic drive_idle(input int n);
    logic fl;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, fl);
  endtask

  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] flags);
    drive_load(a, b);
    drive_shifts(1'b1, flags);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    load = 1'b0;
    clear = 1'b0;
    shift = 1'b0;
    start_count_flag = 1'b1;
    #3;
    checks++;
    if (product !== '0) begin
      errors++;
      $display("FAIL reset_product: got %0d expected 0", product);
    end
    checks++;
    if (counter_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_flag: got %b expected 0", counter_flag);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic;
    logic [W-1:0] flags;
    run_job(8'd13, 8'd11, flags);
    exp_val = exp_q.pop_front();
    checks++;
    if (flags !== 8'h80) begin
      errors++;
      $display("FAIL basic_flags: got %b expected 10000000", flags);
    end
    checks++;
    if (product !== exp_val || product !== 16'd143) begin
      errors++;
      $display("FAIL basic_product: got %0d expected %0d", product, exp_val);
    end
    drive_idle(1);
  endtask

  task automatic test_max;
    logic [W-1:0] flags;
    run_job(8'd255, 8'd255, flags);
    exp_val = exp_q.pop_front();
    checks++;
    if (product !== exp_val || product !== 16'hFE01) begin
      errors++;
      $display("FAIL max_product: got %h expected %h", product, exp_val);
    end
  endtask

  task automatic test_zero_clear;
    logic [W-1:0] flags;
    logic fl;
    run_job(8'd0, 8'd200, flags);
    exp_val = exp_q.pop_front();
    checks++;
    if (product !== exp_val) begin
      errors++;
      $display("FAIL zero_product: got %0d expected %0d", product, exp_val);
    end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, fl);
      checks++;
      if (product !== 16'd0) begin
        errors++;
        $display("FAIL clear_hold_zero[%0d]: got %0d expected 0", i, product);
      end
    end
    run_job(8'd7, 8'd9, flags);
    exp_val = exp_q.pop_front();
    checks++;
    if (product !== exp_val) begin
      errors++;
      $display("FAIL small_product: got %0d expected %0d", product, exp_val);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, fl);
      checks++;
      if (product !== 16'd63) begin
        errors++;
        $display("FAIL clear_hold_63[%0d]: got %0d expected 63", i, product);
      end
    end
  endtask

  task automatic test_midjob_reset;
    logic [W-1:0] flags;
    logic fl;
    drive_load(8'd100, 8'd3);
    void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, fl);
    start_count_flag = 1'b1;
    shift = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (product !== '0) begin
      errors++;
      $display("FAIL midreset_product: got %0d expected 0", product);
    end
    checks++;
    if (counter_flag !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flag: got %b expected 0", counter_flag);
    end
    @(negedge clk);
    rst = 1'b1;
    // Shifts without a fresh load carry no operands, so the result must stay 0.
    drive_shifts(1'b1, flags);
    checks++;
    if (product !== '0) begin
      errors++;
      $display("FAIL postreset_hold: got %0d expected 0", product);
    end
    run_job(8'd100, 8'd3, flags);
    exp_val = exp_q.pop_front();
    checks++;
    if (product !== exp_val) begin
      errors++;
      $display("FAIL postreset_job: got %0d expected %0d", product, exp_val);
    end
  endtask

  task automatic test_priority;
    logic [W-1:0] flags;
    logic fl;
    drive_shifts(1'b1, flags);
    multiplicand = 8'd5;
    multiplier = 8'd6;
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, fl);
    exp_q.push_back(16'd30);
    drive_shifts(1'b1, flags);
    exp_val = exp_q.pop_front();
    checks++;
    if (flags !== 8'h80) begin
      errors++;
      $display("FAIL priority_flags: got %b expected 10000000", flags);
    end
    checks++;
    if (product !== exp_val) begin
      errors++;
      $display("FAIL priority_product: got %0d expected %0d", product, exp_val);
    end
  endtask

  task automatic test_no_count;
    logic [W-1:0] flags;
    logic [2*W-1:0] prev;
    prev = product;
    drive_load(8'd3, 8'd4);
    drive_shifts(1'b0, flags);
    checks++;
    if (flags !== 8'h00) begin
      errors++;
      $display("FAIL nocount_flags: got %b expected 00000000", flags);
    end
    checks++;
    if (product !== prev) begin
      errors++;
      $display("FAIL nocount_product: got %0d expected %0d", product, prev);
    end
    // The uncounted steps still accumulated, so a counted pass now exposes 3*4.
    drive_shifts(1'b1, flags);
    exp_val = exp_q.pop_front();
    checks++;
    if (product !== exp_val) begin
      errors++;
      $display("FAIL nocount_accum: got %0d expected %0d", product, exp_val);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] flags;
    logic [W-1:0] a, b;
    for (int j = 0; j < 8; j++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      run_job(a, b, flags);
      exp_val = exp_q.pop_front();
      checks++;
      if (flags !== 8'h80) begin
        errors++;
        $display("FAIL b2b_flags[%0d]: got %b expected 10000000", j, flags);
      end
      checks++;
      if (product !== exp_val) begin
        errors++;
        $display("FAIL b2b_product[%0d] %0d*%0d: got %0d expected %0d", j, a, b, product, exp_val);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    @(negedge clk);
    test_basic();
    test_max();
    test_zero_clear();
    test_midjob_reset();
    test_priority();
    test_no_count();
    test_back_to_back();
    drive_idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
